// File: rtl/pipe_stall_ctrl.sv
// Central stall/hazard controller: turns the dcache stall into a global halt,
// inserts load-use bubbles and branch flushes, and watches for runaway misses.
module pipe_stall_ctrl #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             mem_stall_i,
  input  logic             idex_memread_i,
  input  logic [4:0]       idex_rt_i,
  input  logic [4:0]       ifid_rs_i,
  input  logic [4:0]       ifid_rt_i,
  input  logic             branch_taken_i,
  output logic             halt_o,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             idex_bubble_o,
  output logic             ifid_flush_o,
  output logic             timeout_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] miss_count_o,
  output logic [CNT_W-1:0] stall_cycles_o,
  output logic [CNT_W-1:0] bubble_count_o
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MISS    = 2'd1,
    TIMEOUT = 2'd2
  } state_e;

  localparam logic [15:0] TIMER_LIM = 16'(TIMEOUT_CYCLES);

  state_e           state_q, state_d;
  logic [15:0]      timer_q, timer_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] miss_count_q, miss_count_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] bubble_count_q, bubble_count_d;
  logic             load_use;
  logic             miss_start;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != {CNT_W{1'b1}})) begin
      return v + CNT_W'(1);
    end
    return v;
  endfunction

  always_comb begin
    load_use = idex_memread_i && (idex_rt_i != 5'd0) &&
               ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));
    halt_o   = mem_stall_i || (state_q == TIMEOUT);
    // A halted pipeline keeps its hazard inputs frozen; they are re-evaluated on release.
    pc_write_o    = halt_o || !load_use;
    ifid_write_o  = halt_o || !load_use;
    idex_bubble_o = !halt_o && load_use;
    ifid_flush_o  = branch_taken_i && !load_use && !halt_o;
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    timeout_d  = timeout_q;
    miss_start = 1'b0;
    case (state_q)
      RUN: begin
        if (mem_stall_i) begin
          state_d    = MISS;
          timer_d    = 16'd1;
          miss_start = 1'b1;
        end
      end
      MISS: begin
        if (!mem_stall_i) begin
          state_d = RUN;
          timer_d = 16'd0;
        end else if (timer_q < TIMER_LIM) begin
          timer_d = timer_q + 16'd1;
        end else begin
          state_d   = TIMEOUT;
          timeout_d = 1'b1;
        end
      end
      TIMEOUT: begin
        state_d = TIMEOUT;
      end
      default: begin
        state_d = RUN;
        timer_d = 16'd0;
      end
    endcase
    miss_count_d   = sat_inc(miss_count_q, miss_start);
    stall_cycles_d = sat_inc(stall_cycles_q, mem_stall_i && (state_q != TIMEOUT));
    bubble_count_d = sat_inc(bubble_count_q, idex_bubble_o);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q        <= RUN;
      timer_q        <= 16'd0;
      timeout_q      <= 1'b0;
      miss_count_q   <= '0;
      stall_cycles_q <= '0;
      bubble_count_q <= '0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      timeout_q      <= timeout_d;
      miss_count_q   <= miss_count_d;
      stall_cycles_q <= stall_cycles_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  assign timeout_o      = timeout_q;
  assign state_o        = state_q;
  assign miss_count_o   = miss_count_q;
  assign stall_cycles_o = stall_cycles_q;
  assign bubble_count_o = bubble_count_q;

endmodule

// File: doc/pipe_stall_ctrl.md
# pipe_stall_ctrl

- Central stall/hazard controller for the 5-stage pipelined CPU with one-way data cache.
- Converts the dcache stall request into the common `halt` that freezes PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Generates load-use bubbles and branch flushes, with `halt` taking priority over both.
- Adds a miss-duration watchdog and saturating performance counters.

## Interface
- `TIMEOUT_CYCLES`, default 1024: longest legal continuous cache stall in cycles (1..65535).
- `CNT_W`, default 16: width of each performance counter.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-low.
- `mem_stall_i`  in  1  dcache stall request from the MEM stage.
- `idex_memread_i`  in  1  ID/EX instruction is a load.
- `idex_rt_i`  in  5  destination register of that load.
- `ifid_rs_i`, `ifid_rt_i`  in  5 each  source registers of the IF/ID instruction.
- `branch_taken_i`  in  1  branch resolved taken in ID.
- `halt_o`  out  1  freeze all pipeline registers and PC.
- `pc_write_o`  out  1  PC write enable.
- `ifid_write_o`  out  1  IF/ID write enable.
- `idex_bubble_o`  out  1  zero the ID/EX control fields.
- `ifid_flush_o`  out  1  clear IF/ID.
- `timeout_o`  out  1  watchdog fired (sticky).
- `state_o`  out  2  FSM state: RUN=0, MISS=1, TIMEOUT=2.
- `miss_count_o`  out  `CNT_W`  number of cache misses.
- `stall_cycles_o`  out  `CNT_W`  number of cycles halted by the cache.
- `bubble_count_o`  out  `CNT_W`  number of load-use bubbles inserted.

## Operation
Load-use detection:
- `load_use` = `idex_memread_i` & (`idex_rt_i` != 0) & (`idex_rt_i` == `ifid_rs_i` | `idex_rt_i` == `ifid_rt_i`).

Halt:
- `halt_o` = `mem_stall_i` | (state == TIMEOUT).
- `halt_o` is combinational, so the pipeline freezes in the same cycle the cache requests a stall.

Hazard outputs:
- While `halt_o`=1, hazard actions are suppressed: `pc_write_o`=1, `ifid_write_o`=1, `idex_bubble_o`=0, `ifid_flush_o`=0. The frozen inputs are re-evaluated after release.
- Otherwise, on `load_use`: `pc_write_o`=0, `ifid_write_o`=0, `idex_bubble_o`=1.
- `ifid_flush_o` = `branch_taken_i` & ~`load_use` & ~`halt_o`. A branch stalled by a load-use hazard is not flushed that cycle.

FSM, with a 16-bit stall timer:
- RUN, `mem_stall_i`=1 → MISS; timer←1; `miss_count_o`++.
- MISS, `mem_stall_i`=1, timer < `TIMEOUT_CYCLES` → stay in MISS; timer++.
- MISS, `mem_stall_i`=1, timer == `TIMEOUT_CYCLES` → TIMEOUT.
- MISS, `mem_stall_i`=0 → RUN; timer←0.
- TIMEOUT: terminal until reset. `halt_o`=1 and `timeout_o`=1 regardless of inputs.
- A stall of exactly `TIMEOUT_CYCLES` consecutive cycles is legal. Cycle `TIMEOUT_CYCLES`+1 enters TIMEOUT at its closing edge.
- Back-to-back misses (stall drops for one cycle, then reasserts) go MISS→RUN→MISS and count as two misses.

Counters:
- `stall_cycles_o`++ every cycle with `mem_stall_i`=1 and state != TIMEOUT.
- `bubble_count_o`++ every cycle `idex_bubble_o`=1.
- All counters saturate at all-ones; they never wrap.

## Timing
- Reset (async, `rst_i`=0): state=RUN, timer=0, all counters=0, `timeout_o`=0.
- During reset the combinational outputs follow their equations in RUN: `halt_o`=`mem_stall_i`.
- `halt_o`, `pc_write_o`, `ifid_write_o`, `idex_bubble_o`, `ifid_flush_o`: zero-latency combinational from inputs plus state.
- `state_o`, `timeout_o`, counters: registered; they update at the edge closing the qualifying cycle.
- Reset asserted mid-miss: returns to RUN immediately. A `mem_stall_i` still high after reset release starts a new miss (counted).

## Test plan
- Reset with `mem_stall_i`=0 → `halt_o`=0, `pc_write_o`=1, `ifid_write_o`=1, `state_o`=0, all counters 0.
- `mem_stall_i` high 5 cycles → `halt_o`=1 for exactly those 5 cycles, `state_o`=1 from the 2nd cycle, `miss_count_o`=1, `stall_cycles_o`=5, `state_o`=0 after release.
- `idex_memread_i`=1, `idex_rt_i`=8, `ifid_rs_i`=8 → `pc_write_o`=0, `ifid_write_o`=0, `idex_bubble_o`=1, `bubble_count_o`=1. Repeat with `idex_rt_i`=0 → no bubble.
- Load-use plus `branch_taken_i`=1 → `ifid_flush_o`=0. The same case with `mem_stall_i`=1 → no bubble, no flush, `halt_o`=1.
- `TIMEOUT_CYCLES`=8:
  - Stall 8 cycles → back to RUN.
  - Stall 9 cycles → `timeout_o`=1, `halt_o` stays 1 after `mem_stall_i` drops, until `rst_i` pulses low.
- `CNT_W`=4, 20 bubbles → `bubble_count_o`=15. Assert reset mid-miss → RUN, counters 0.
